// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the byte-serial load/store unit: FSM encoding and widths.
package load_store_unit_pkg;

  localparam int ADDR_W = 8;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: turns 8/16-bit CPU accesses into one or two byte
// accesses on a combinational-read, edge-write data memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_wide,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              dm_W,
  output logic [ADDR_W-1:0] dm_address,
  output logic [BYTE_W-1:0] dm_data_in,
  input  logic [BYTE_W-1:0] dm_data_out
);

  lsu_state_t        state;
  logic              write_q;
  logic              wide_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;

  // Byte sent in BYTE0; a narrow store always sends the low byte.
  function automatic logic [BYTE_W-1:0] first_wbyte(input logic [WORD_W-1:0] w,
                                                    input logic wide);
    if (!wide || LITTLE_ENDIAN) return w[7:0];
    else                        return w[15:8];
  endfunction

  // Byte sent in BYTE1 (wide accesses only).
  function automatic logic [BYTE_W-1:0] second_wbyte(input logic [WORD_W-1:0] w);
    if (LITTLE_ENDIAN) return w[15:8];
    else               return w[7:0];
  endfunction

  // Placement of the byte read in BYTE0; narrow loads zero-extend.
  function automatic logic [WORD_W-1:0] first_rword(input logic [BYTE_W-1:0] b,
                                                    input logic wide);
    if (!wide || LITTLE_ENDIAN) return {8'h00, b};
    else                        return {b, 8'h00};
  endfunction

  // Drive the memory port from the current byte phase; write strobe masked by reset
  always_comb begin
    dm_W       = 1'b0;
    dm_address = '0;
    dm_data_in = '0;
    case (state)
      BYTE0: begin
        dm_W       = write_q & ~reset;
        dm_address = addr_q;
        dm_data_in = first_wbyte(wdata_q, wide_q);
      end
      BYTE1: begin
        dm_W       = write_q & ~reset;
        dm_address = addr_q + ADDR_W'(1);
        dm_data_in = second_wbyte(wdata_q);
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake outputs and read-data assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      wide_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            wide_q     <= req_wide;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            req_ready  <= 1'b0;
            state      <= BYTE0;
          end
        end
        BYTE0: begin
          if (!write_q) resp_rdata <= first_rword(dm_data_out, wide_q);
          if (wide_q) begin
            state <= BYTE1;
          end else begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end
        end
        BYTE1: begin
          if (!write_q) begin
            if (LITTLE_ENDIAN) resp_rdata[15:8] <= dm_data_out;
            else               resp_rdata[7:0]  <= dm_data_out;
          end
          state      <= DONE;
          resp_valid <= 1'b1;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: little-endian and big-endian
// instances, each attached to its own 256-byte memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;
  int          wr_count = 0;

  // little-endian instance
  logic        req_valid, req_ready, req_write, req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_rdata;
  logic        dm_W;
  logic [7:0]  dm_address, dm_data_in, dm_data_out;
  logic [7:0]  mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr, pl_data;

  // big-endian instance
  logic        be_req_valid, be_req_ready, be_req_write, be_req_wide;
  logic [7:0]  be_req_addr;
  logic [15:0] be_req_wdata;
  logic        be_resp_valid, be_resp_ready;
  logic [15:0] be_resp_rdata;
  logic        be_dm_W;
  logic [7:0]  be_dm_address, be_dm_data_in, be_dm_data_out;
  logic [7:0]  be_mem [256];

  always #5 clk = ~clk;

  load_store_unit #(.LITTLE_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .dm_W(dm_W), .dm_address(dm_address), .dm_data_in(dm_data_in),
    .dm_data_out(dm_data_out)
  );

  load_store_unit #(.LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .reset(reset),
    .req_valid(be_req_valid), .req_ready(be_req_ready), .req_write(be_req_write),
    .req_wide(be_req_wide), .req_addr(be_req_addr), .req_wdata(be_req_wdata),
    .resp_valid(be_resp_valid), .resp_ready(be_resp_ready), .resp_rdata(be_resp_rdata),
    .dm_W(be_dm_W), .dm_address(be_dm_address), .dm_data_in(be_dm_data_in),
    .dm_data_out(be_dm_data_out)
  );

  assign dm_data_out    = mem[dm_address];
  assign be_dm_data_out = be_mem[be_dm_address];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (dm_W) mem[dm_address] <= dm_data_in;
    if (dm_W) wr_count++;
  end

  always @(posedge clk) begin
    if (be_dm_W) be_mem[be_dm_address] <= be_dm_data_in;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 16'h0000) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0000", resp_rdata); end
    checks++; if (dm_W !== 1'b0 || dm_address !== 8'h00 || dm_data_in !== 8'h00) begin
      failures++; $display("FAIL reset_dm_idle got W=%b a=%h d=%h exp 0/00/00", dm_W, dm_address, dm_data_in); end
  endtask

  task automatic test_narrow_store();
    int w0;
    w0 = wr_count;
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b0; req_addr = 8'h10; req_wdata = 16'h00A5;
    step();
    req_valid = 1'b0;
    checks++; if (dm_W !== 1'b1 || dm_address !== 8'h10 || dm_data_in !== 8'hA5) begin
      failures++; $display("FAIL nstore_byte0 got W=%b a=%h d=%h exp 1/10/a5", dm_W, dm_address, dm_data_in); end
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL nstore_busy got ready=%b valid=%b exp 0/0", req_ready, resp_valid); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0000) begin
      failures++; $display("FAIL nstore_resp got valid=%b rdata=%h exp 1/0000", resp_valid, resp_rdata); end
    checks++; if (mem[8'h10] !== 8'hA5) begin failures++; $display("FAIL nstore_mem got=%h exp=a5", mem[8'h10]); end
    checks++; if (dm_W !== 1'b0 || dm_address !== 8'h00) begin
      failures++; $display("FAIL nstore_done_dm got W=%b a=%h exp 0/00", dm_W, dm_address); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL nstore_release got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
    checks++; if (wr_count - w0 !== 1) begin failures++; $display("FAIL nstore_pulses got=%0d exp=1", wr_count - w0); end
  endtask

  task automatic test_wide_load_backpressure();
    preload(8'h20, 8'h34);
    preload(8'h21, 8'h12);
    req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b1; req_addr = 8'h20; req_wdata = 16'hFFFF;
    step();
    req_valid = 1'b0;
    checks++; if (dm_address !== 8'h20 || dm_W !== 1'b0) begin
      failures++; $display("FAIL wload_byte0 got a=%h W=%b exp 20/0", dm_address, dm_W); end
    step();
    checks++; if (dm_address !== 8'h21 || dm_W !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL wload_byte1 got a=%h W=%b valid=%b exp 21/0/0", dm_address, dm_W, resp_valid); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h1234) begin
      failures++; $display("FAIL wload_resp got valid=%b rdata=%h exp 1/1234", resp_valid, resp_rdata); end
    // hold the response while a competing request is presented
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b0; req_addr = 8'h55; req_wdata = 16'h0077;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h1234 || req_ready !== 1'b0 || dm_W !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d] got valid=%b rdata=%h ready=%b W=%b exp 1/1234/0/0",
                             i, resp_valid, resp_rdata, req_ready, dm_W); end
    end
    // response taken while a new narrow load is already asserted
    req_write = 1'b0; req_addr = 8'h21;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dm_address !== 8'h00) begin
      failures++; $display("FAIL b2b_not_taken got valid=%b ready=%b a=%h exp 0/1/00", resp_valid, req_ready, dm_address); end
    step();
    req_valid = 1'b0;
    checks++; if (dm_address !== 8'h21 || req_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_accept got a=%h ready=%b exp 21/0", dm_address, req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0012) begin
      failures++; $display("FAIL nload_resp got valid=%b rdata=%h exp 1/0012", resp_valid, resp_rdata); end
    checks++; if (mem[8'h55] === 8'h77) begin failures++; $display("FAIL bp_ignored got mem55=%h exp not 77", mem[8'h55]); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_wrap_store();
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1; req_addr = 8'hFF; req_wdata = 16'hBEEF;
    step();
    req_valid = 1'b0;
    checks++; if (dm_address !== 8'hFF || dm_data_in !== 8'hEF || dm_W !== 1'b1) begin
      failures++; $display("FAIL wrap_byte0 got a=%h d=%h W=%b exp ff/ef/1", dm_address, dm_data_in, dm_W); end
    step();
    checks++; if (dm_address !== 8'h00 || dm_data_in !== 8'hBE || dm_W !== 1'b1) begin
      failures++; $display("FAIL wrap_byte1 got a=%h d=%h W=%b exp 00/be/1", dm_address, dm_data_in, dm_W); end
    step();
    checks++; if (mem[8'hFF] !== 8'hEF || mem[8'h00] !== 8'hBE) begin
      failures++; $display("FAIL wrap_mem got ff=%h 00=%h exp ef/be", mem[8'hFF], mem[8'h00]); end
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0000) begin
      failures++; $display("FAIL wrap_resp got valid=%b rdata=%h exp 1/0000", resp_valid, resp_rdata); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    preload(8'h41, 8'h99);
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1; req_addr = 8'h40; req_wdata = 16'h5678;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (dm_address !== 8'h41 || dm_W !== 1'b1) begin
      failures++; $display("FAIL rmid_byte1 got a=%h W=%b exp 41/1", dm_address, dm_W); end
    reset = 1'b1;
    #1;
    checks++; if (dm_W !== 1'b0) begin failures++; $display("FAIL rmid_gate got W=%b exp 0", dm_W); end
    step();
    reset = 1'b0;
    checks++; if (mem[8'h41] !== 8'h99 || mem[8'h40] !== 8'h78) begin
      failures++; $display("FAIL rmid_mem got 40=%h 41=%h exp 78/99", mem[8'h40], mem[8'h41]); end
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dm_address !== 8'h00) begin
      failures++; $display("FAIL rmid_state got valid=%b ready=%b a=%h exp 0/1/00", resp_valid, req_ready, dm_address); end
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_after got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_big_endian();
    be_req_valid = 1'b1; be_req_write = 1'b1; be_req_wide = 1'b1; be_req_addr = 8'h30; be_req_wdata = 16'h1234;
    step();
    be_req_valid = 1'b0;
    checks++; if (be_dm_address !== 8'h30 || be_dm_data_in !== 8'h12) begin
      failures++; $display("FAIL be_byte0 got a=%h d=%h exp 30/12", be_dm_address, be_dm_data_in); end
    step();
    step();
    checks++; if (be_mem[8'h30] !== 8'h12 || be_mem[8'h31] !== 8'h34) begin
      failures++; $display("FAIL be_store_mem got 30=%h 31=%h exp 12/34", be_mem[8'h30], be_mem[8'h31]); end
    be_resp_ready = 1'b1;
    step();
    be_resp_ready = 1'b0;
    be_req_valid = 1'b1; be_req_write = 1'b0; be_req_wide = 1'b1; be_req_addr = 8'h30;
    step();
    be_req_valid = 1'b0;
    step();
    step();
    checks++; if (be_resp_valid !== 1'b1 || be_resp_rdata !== 16'h1234) begin
      failures++; $display("FAIL be_load got valid=%b rdata=%h exp 1/1234", be_resp_valid, be_resp_rdata); end
    be_resp_ready = 1'b1;
    step();
    be_resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    be_req_valid = 1'b0; be_req_write = 1'b0; be_req_wide = 1'b0; be_req_addr = '0; be_req_wdata = '0;
    be_resp_ready = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_narrow_store();
    test_wide_load_backpressure();
    test_wrap_store();
    test_reset_mid();
    test_big_endian();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: LITTLE_ENDIAN, default 1, 1 = low byte at addr and high byte at addr+1; 0 = reversed.
REQ-002 One clock; reset is synchronous and active-high; ports clk and reset.
REQ-003 clk  input  1  rising-edge clock shared with the data memory.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_wide  input  1  1 = 16-bit access, 0 = 8-bit access.
REQ-009 req_addr  input  8  byte address.
REQ-010 req_wdata  input  16  store data; bits [15:8] ignored when narrow.
REQ-011 resp_valid  output  1  access complete; resp_rdata valid.
REQ-012 resp_ready  input  1  CPU takes the response.
REQ-013 resp_rdata  output  16  load result; 0 for stores.
REQ-014 dm_W  output  1  write strobe to the data memory.
REQ-015 dm_address  output  8  data memory address.
REQ-016 dm_data_in  output  8  data memory write byte.
REQ-017 dm_data_out  input  8  data memory combinational read byte.

Function
REQ-018 The FSM SHALL have these states: IDLE, BYTE0, BYTE1, DONE.
REQ-019 IDLE: req_ready=1; on req_valid at a clk edge, latch write, wide, addr and wdata, then go to BYTE0.
REQ-020 Outside IDLE: req_ready=0; requests are ignored, not queued.
REQ-021 BYTE0: dm_address=addr_q; dm_W=write_q; dm_data_in=first byte per LITTLE_ENDIAN; a load captures dm_data_out at the edge ending the cycle.
REQ-022 BYTE0 exit: wide goes to BYTE1; narrow goes to DONE.
REQ-023 BYTE1: dm_address=addr_q+1 modulo 256 (0xFF wraps to 0x00); dm_W=write_q; second byte; exit to DONE.
REQ-024 DONE: resp_valid=1; resp_rdata held stable until resp_ready=1 at an edge; then go to IDLE.
REQ-025 Back-to-back: no request is accepted in the DONE->IDLE transition cycle; a new request is accepted one cycle after IDLE is re-entered at the earliest.
REQ-026 Narrow load: resp_rdata[15:8]=0. Store: resp_rdata=0.
REQ-027 Latency (accept edge k): narrow resp_valid after edge k+1; wide after edge k+2.
REQ-028 In IDLE and DONE: dm_W=0, dm_address=0, dm_data_in=0.
REQ-029 dm_W SHALL be combinationally gated by !reset, so no memory write occurs on the edge that applies reset.
REQ-030 Simultaneous resp_ready and a new req_valid in DONE: the response completes; the request is not accepted that cycle.

Reset
REQ-031 On an edge with reset=1: state=IDLE; all latched registers cleared; resp_valid=0; resp_rdata=0.
REQ-032 Reset mid-operation (BYTE0/BYTE1/DONE): the transfer is abandoned; no response is issued; a wide store may leave only its first byte written.
REQ-033 After reset deasserts, req_ready=1 in the first cycle.

Structure
REQ-034 The shared package SHALL hold: the state encoding (2-bit, 4 states); ADDR_W=8; BYTE_W=8; WORD_W=16.
REQ-035 Single flat module; no sub-module; the data memory is instantiated alongside it, not inside it.

Verification
REQ-036 Narrow store: addr 0x10, wdata 0x00A5, narrow -> one dm_W pulse, dm_address=0x10, dm_data_in=0xA5; resp_valid after edge k+1; resp_rdata=0.
REQ-037 Wide load, LITTLE_ENDIAN=1, mem[0x20]=0x34, mem[0x21]=0x12 -> resp_rdata=0x1234 after edge k+2; dm_W stays 0.
REQ-038 Wide store at 0xFF, wdata 0xBEEF -> mem[0xFF]=0xEF, mem[0x00]=0xBE (wrap).
REQ-039 Backpressure: resp_ready=0 for 3 cycles -> resp_valid and resp_rdata held; req_ready=0; a new req_valid is ignored.
REQ-040 Reset asserted during BYTE1 of a wide store to 0x40 -> mem[0x41] unchanged; state IDLE; resp_valid=0; req_ready=1 in the next cycle.
REQ-041 LITTLE_ENDIAN=0 wide store 0x1234 at 0x30 -> mem[0x30]=0x12, mem[0x31]=0x34.
